// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared state encoding and width helper for the SPI initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_t;

    // Width needed to express a length of 0..maxlen bits.
    function automatic int spi_len_w(input int maxlen);
        return $clog2(maxlen) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_ctrl_if
//  Description : Command handshake and SPI pin bundle for spi_master_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_ctrl_if #(
    parameter int SPI_MAXLEN = 32
) ();
    import spi_pkg::*;

    localparam int LEN_W = spi_len_w(SPI_MAXLEN);

    logic                  start;
    logic [SPI_MAXLEN-1:0] tx_data;
    logic [LEN_W-1:0]      n_clks;
    logic                  busy;
    logic                  done;
    logic [SPI_MAXLEN-1:0] rx_data;
    logic                  SCLK;
    logic                  SS_N;
    logic                  MOSI;
    logic                  MISO;

    modport master (
        input  start, tx_data, n_clks, MISO,
        output busy, done, rx_data, SCLK, SS_N, MOSI
    );

    modport slave (
        output start, tx_data, n_clks, MISO,
        input  busy, done, rx_data, SCLK, SS_N, MOSI
    );
endinterface
`default_nettype wire

// File: rtl/spi_half_tick.sv
`default_nettype none
// ============================================================================
//  Module      : spi_half_tick
//  Description : Pulses tick every H cycles while en is high; idles at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_half_tick #(
    parameter int H = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = (H > 1) ? $clog2(H) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(H - 1));

    // Holding the count at zero while disabled makes every enable start a fresh period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_ctrl
//  Description : Mode-0 SPI initiator, 1..SPI_MAXLEN bit transfers, MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIVIDE = 100,
    parameter int SPI_MAXLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spi_master_ctrl_if.master        bus
);
    localparam int H     = CLK_DIVIDE / 2;
    localparam int LEN_W = spi_len_w(SPI_MAXLEN);

    spi_state_t            state;
    spi_state_t            state_nxt;
    logic                  tick;
    logic                  accept;
    logic                  bits_left;
    logic [LEN_W-1:0]      n_req;
    logic [SPI_MAXLEN-1:0] tx_aligned;
    logic [SPI_MAXLEN-1:0] shift_tx;
    logic [SPI_MAXLEN-1:0] shift_rx;
    logic [LEN_W-1:0]      bit_cnt;
    logic                  sclk;
    logic                  ss_n;
    logic                  mosi;
    logic                  busy;
    logic                  done;
    logic [SPI_MAXLEN-1:0] rx_data;

    spi_half_tick #(.H(H)) u_half_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .tick  (tick)
    );

    assign accept    = (state == IDLE) && bus.start && (bus.n_clks != '0);
    assign n_req     = (bus.n_clks > LEN_W'(SPI_MAXLEN)) ? LEN_W'(SPI_MAXLEN) : bus.n_clks;
    assign bits_left = (bit_cnt != '0);
    // Left-justify the word so the first bit to send is always the MSB of shift_tx.
    assign tx_aligned = bus.tx_data << (LEN_W'(SPI_MAXLEN) - n_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (tick)   state_nxt = HIGH;
            HIGH:    if (tick)   state_nxt = bits_left ? LOW : HOLD;
            LOW:     if (tick)   state_nxt = HIGH;
            HOLD:    if (tick)   state_nxt = GAP;
            GAP:     if (tick)   state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_tx <= '0;
            shift_rx <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            ss_n     <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mosi     <= tx_aligned[SPI_MAXLEN-1];
                        shift_tx <= tx_aligned << 1;
                        bit_cnt  <= n_req;
                        shift_rx <= '0;
                        ss_n     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SETUP, LOW: begin
                    if (tick) begin
                        sclk     <= 1'b1;
                        shift_rx <= {shift_rx[SPI_MAXLEN-2:0], bus.MISO};
                        bit_cnt  <= bit_cnt - LEN_W'(1);
                    end
                end
                HIGH: begin
                    if (tick) begin
                        sclk <= 1'b0;
                        if (bits_left) begin
                            mosi     <= shift_tx[SPI_MAXLEN-1];
                            shift_tx <= shift_tx << 1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        ss_n    <= 1'b1;
                        mosi    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= shift_rx;
                    end
                end
                GAP: begin
                    if (tick) busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.SCLK    = sclk;
    assign bus.SS_N    = ss_n;
    assign bus.MOSI    = mosi;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.rx_data = rx_data;
endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Synthesizable SPI initiator: drives SCLK, SS_N and MOSI and captures MISO for a transfer of 1..SPI_MAXLEN bits, MSB first. It is the controller counterpart to the team's SPI responder.
- Mode 0: SCLK idles low; MOSI changes on SCLK falling edges; MISO is sampled on SCLK rising edges.
- Sits between a local register/command interface (start/busy/done) and the SPI pins.

Parameters:
CLK_DIVIDE, 100, clk cycles per SCLK period; must be even and >=4; half period H = CLK_DIVIDE/2.
SPI_MAXLEN, 32, maximum transfer length in bits.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; accepted only in IDLE.
tx_data  in  SPI_MAXLEN  data to send; bits [n-1:0] are used, bit n-1 goes first.
n_clks  in  $clog2(SPI_MAXLEN)+1  transfer length n in bits.
busy  out  1  high from acceptance through end of GAP.
done  out  1  one-cycle pulse when SS_N rises.
rx_data  out  SPI_MAXLEN  received word; valid when done is high and held until the next acceptance.
SCLK  out  1  SPI clock, registered.
SS_N  out  1  active-low slave select, registered.
MOSI  out  1  serial data out, registered.
MISO  in  1  serial data in.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer): SCLK=0, SS_N=1, MOSI=0, busy=0, done=0, rx_data=0, state=IDLE, all counters=0.
- State set: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE, start=1 and n_clks!=0:
  - latch tx_data into shift_tx;
  - latch n = min(n_clks, SPI_MAXLEN);
  - clear rx shift register;
  - next cycle (cycle 1): SS_N=0, MOSI=tx_data[n-1], busy=1; go to SETUP.
- IDLE, start=1 and n_clks==0: ignored; no outputs change.
- Every state except IDLE waits H cycles via the half-period counter, then transitions.
- SETUP -> HIGH:
  - SCLK goes 1;
  - on the same clk edge, MISO is shifted into the LSB of the rx shift register;
  - bit counter decrements.
- HIGH -> LOW:
  - SCLK goes 0;
  - if bits remain, MOSI takes the next lower tx bit;
  - if no bits remain, MOSI holds its value and the next state is HOLD.
- LOW -> HIGH when bits remain.
- HOLD -> GAP:
  - SS_N=1, MOSI=0, done=1 for one cycle;
  - rx_data = received bits in [n-1:0], upper bits zero.
- GAP -> IDLE after H cycles; busy=0 on entry to IDLE.
  - GAP guarantees SS_N stays high >= H cycles between transfers.
- Timing, cycle 0 = start accepted:
  - k-th SCLK rise at 1+H+2H(k-1);
  - last fall at 1+2Hn;
  - SS_N rise and done at 1+2Hn+H;
  - next start accepted at 1+2Hn+2H or later.
- start while busy=1 is ignored. tx_data and n_clks changes after acceptance have no effect.
- Exactly n SCLK rising edges per transfer. No SCLK edges occur while SS_N=1.

Decomposition:
- Package spi_pkg:
  - typedef enum logic[2:0] spi_state_t {IDLE, SETUP, HIGH, LOW, HOLD, GAP};
  - function spi_len_w(maxlen) returning $clog2(maxlen)+1.
- Sub-module spi_half_tick(clk, rst_n, en, tick), parameter H:
  - counter that pulses tick every H cycles while en=1;
  - restarts from 0 when en rises.
- Top module holds the FSM, the shift registers and the bit counter.

Test Plan:
All scenarios use CLK_DIVIDE=4 (H=2), SPI_MAXLEN=32, with the team's SPI responder model attached.
1. n_clks=8, tx_data=0xA5, responder test_data=0x3C:
   - rx_data=0x0000003C; responder captures 0xA5;
   - done at cycle 35 after acceptance; exactly 8 SCLK rises.
2. n_clks=32, tx_data=0xDEADBEEF, test_data=0x12345678:
   - rx_data=0x12345678; responder captures 0xDEADBEEF; done at cycle 131.
3. n_clks=1, tx_data=0x1, test_data=0x0:
   - one SCLK pulse; MOSI=1 during it; rx_data=0; done at cycle 7.
4. Busy handling:
   - start pulses at cycles 5 and 20 of a transfer are ignored;
   - start held high continuously: the second transfer begins at cycle 1+2Hn+2H;
   - SS_N stays high >= 2 cycles between transfers.
5. Assert rst_n=0 mid-transfer after 3 SCLK rises:
   - SCLK=0, SS_N=1, busy=0, rx_data=0 in the same cycle, without waiting for clk;
   - then scenario 1 repeats and passes.
6. Length edge cases:
   - n_clks=0: no SS_N activity, busy stays 0;
   - n_clks=33: clamped to 32, 32 SCLK rises observed.
